// File: rtl/clk_div_ratio_ctrl_if.sv
// Divisor-change request bus: two requesters, level req/ack 4-phase handshake.
interface clk_div_ratio_ctrl_if #(
    parameter int W = 8
);
    logic [1:0]   req;
    logic [W-1:0] div_in0;
    logic [W-1:0] div_in1;
    logic [1:0]   ack;
    logic         err;

    modport master (
        output req, div_in0, div_in1,
        input  ack, err
    );

    modport slave (
        input  req, div_in0, div_in1,
        output ack, err
    );
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// Programmable-ratio clock divider with a round-robin arbitrated divisor update
// that is applied only on a period boundary so the output never emits a runt.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no request in flight; arbitrate among raised req bits
// S_PEND | legal divisor latched; waiting for the next period boundary
// S_ACK  | ack (and err) held for the granted requester until req drops
module clk_div_ratio_ctrl #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    clk_div_ratio_ctrl_if.slave       bus,
    output logic                      o_busy,
    output logic [W-1:0]              o_div_cur,
    output logic                      o_div_clk,
    output logic                      o_clk_en
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_ACK
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] TWO = W'(2);
    localparam logic [W-1:0] DEF = W'(DEFAULT_DIV);

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0] r_div_cur, w_div_nxt;
    logic [W-1:0] r_pend, w_pend_nxt;
    logic         r_gnt, w_gnt_nxt;
    logic         r_prio, w_prio_nxt;
    logic [1:0]   r_ack, w_ack_nxt;
    logic         r_err, w_err_nxt;
    logic         r_div_clk, w_div_clk_nxt;
    logic         r_clk_en, w_clk_en_nxt;

    logic         w_last;
    logic         w_boundary;
    logic         w_sel;
    logic [W-1:0] w_sel_div;
    logic [W:0]   w_half;

    assign w_last     = (r_cnt == r_div_cur - ONE);
    assign w_boundary = !i_en || w_last;

    // Contended request goes to the pointer; otherwise to whoever is asking.
    assign w_sel     = (bus.req == 2'b11) ? r_prio : bus.req[1];
    assign w_sel_div = w_sel ? bus.div_in1 : bus.div_in0;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cur;
        w_pend_nxt  = r_pend;
        w_gnt_nxt   = r_gnt;
        w_prio_nxt  = r_prio;
        w_ack_nxt   = r_ack;
        w_err_nxt   = r_err;

        if (!i_en) begin
            w_cnt_nxt = r_div_cur - ONE;
        end else if (w_last) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + ONE;
        end

        case (r_state)
            S_IDLE: begin
                if (|bus.req) begin
                    w_gnt_nxt  = w_sel;
                    w_prio_nxt = ~w_sel;
                    w_pend_nxt = w_sel_div;
                    if (w_sel_div < TWO) begin
                        w_ack_nxt   = w_sel ? 2'b10 : 2'b01;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (w_boundary) begin
                    w_div_nxt   = r_pend;
                    w_cnt_nxt   = i_en ? '0 : r_pend - ONE;
                    w_ack_nxt   = r_gnt ? 2'b10 : 2'b01;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!bus.req[r_gnt]) begin
                    w_ack_nxt   = 2'b00;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the decode of the next count.
        w_half        = ({1'b0, w_div_nxt} + {{W{1'b0}}, 1'b1}) >> 1;
        w_div_clk_nxt = ({1'b0, w_cnt_nxt} < w_half);
        w_clk_en_nxt  = (w_cnt_nxt == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= DEF - ONE;
            r_div_cur <= DEF;
            r_pend    <= DEF;
            r_gnt     <= 1'b0;
            r_prio    <= 1'b0;
            r_ack     <= 2'b00;
            r_err     <= 1'b0;
            r_div_clk <= 1'b0;
            r_clk_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div_cur <= w_div_nxt;
            r_pend    <= w_pend_nxt;
            r_gnt     <= w_gnt_nxt;
            r_prio    <= w_prio_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_div_clk <= w_div_clk_nxt;
            r_clk_en  <= w_clk_en_nxt;
        end
    end

    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign o_busy    = (r_state != S_IDLE);
    assign o_div_cur = r_div_cur;
    assign o_div_clk = r_div_clk;
    assign o_clk_en  = r_clk_en;
endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Bench for clk_div_ratio_ctrl: constant vector table, directed corner cases,
// and randomized handshakes checked every cycle against a period-level model.
module tb_clk_div_ratio_ctrl;
    localparam int W   = 8;
    localparam int DEF = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         busy;
    logic [W-1:0] div_cur;
    logic         div_clk;
    logic         clk_en;

    clk_div_ratio_ctrl_if #(.W(W)) bus ();

    clk_div_ratio_ctrl #(.W(W), .DEFAULT_DIV(DEF)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .bus       (bus),
        .o_busy    (busy),
        .o_div_cur (div_cur),
        .o_div_clk (div_clk),
        .o_clk_en  (clk_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: position within the output period plus handshake phase.
    int m_pos, m_div, m_phase, m_g, m_pend, m_prio, m_ack, m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int r;
        int nxt;
        r = int'(bus.req);
        if (rst) begin
            m_div = DEF; m_pos = DEF - 1; m_phase = 0; m_prio = 0;
            m_ack = 0; m_err = 0; m_g = 0; m_pend = DEF;
        end else begin
            nxt = en ? (m_pos + 1) % m_div : m_div - 1;
            if (m_phase == 0) begin
                if (r != 0) begin
                    m_g    = (r == 3) ? m_prio : ((r == 2) ? 1 : 0);
                    m_prio = 1 - m_g;
                    m_pend = (m_g == 1) ? int'(bus.div_in1) : int'(bus.div_in0);
                    if (m_pend < 2) begin
                        m_ack = 1 << m_g; m_err = 1; m_phase = 2;
                    end else begin
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (!en || m_pos == m_div - 1) begin
                    m_div = m_pend;
                    nxt   = en ? 0 : m_pend - 1;
                    m_ack = 1 << m_g; m_err = 0; m_phase = 2;
                end
            end else begin
                if (((r >> m_g) & 1) == 0) begin
                    m_ack = 0; m_err = 0; m_phase = 0;
                end
            end
            m_pos = nxt;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("busy",    int'(busy),    (m_phase != 0) ? 1 : 0);
        chk("ack",     int'(bus.ack), m_ack);
        chk("err",     int'(bus.err), m_err);
        chk("div_cur", int'(div_cur), m_div);
        chk("div_clk", int'(div_clk), (2 * m_pos < m_div) ? 1 : 0);
        chk("clk_en",  int'(clk_en),  (m_pos == 0) ? 1 : 0);
    endtask

    task automatic wait_ack(input logic [1:0] mask, input int budget);
        int n;
        n = 0;
        while (bus.ack != mask && n < budget) begin
            cycle();
            n++;
        end
        chk("wait_ack_timeout", (bus.ack == mask) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       e_dc;
        logic       e_ce;
        logic [1:0] e_ack;
        logic       e_busy;
        logic [7:0] e_div;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic [1:0] q,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic dc, input logic ce, input logic [1:0] a,
                       input logic b, input logic [7:0] dv);
        vec_t v;
        v.rst = r; v.en = e; v.req = q; v.d0 = d0; v.d1 = d1;
        v.e_dc = dc; v.e_ce = ce; v.e_ack = a; v.e_busy = b; v.e_div = dv;
        tbl.push_back(v);
    endtask

    initial begin
        logic [6:0] pat;

        rst = 1'b1; en = 1'b1;
        bus.req = 2'b00; bus.div_in0 = '0; bus.div_in1 = '0;

        //   rst en  req    d0 d1   dc ce ack    busy div
        add(1, 1, 2'b00, 0, 0,   0, 0, 2'b00, 0, 5);
        add(0, 1, 2'b00, 0, 0,   1, 1, 2'b00, 0, 5);
        add(0, 1, 2'b00, 0, 0,   1, 0, 2'b00, 0, 5);
        add(0, 1, 2'b00, 0, 0,   1, 0, 2'b00, 0, 5);
        add(0, 1, 2'b00, 0, 0,   0, 0, 2'b00, 0, 5);
        add(0, 1, 2'b00, 0, 0,   0, 0, 2'b00, 0, 5);
        add(0, 1, 2'b00, 0, 0,   1, 1, 2'b00, 0, 5);
        add(0, 1, 2'b00, 0, 0,   1, 0, 2'b00, 0, 5);
        add(0, 1, 2'b01, 4, 0,   1, 0, 2'b00, 1, 5);
        add(0, 1, 2'b01, 4, 0,   0, 0, 2'b00, 1, 5);
        add(0, 1, 2'b01, 4, 0,   0, 0, 2'b00, 1, 5);
        add(0, 1, 2'b01, 4, 0,   1, 1, 2'b01, 1, 4);
        add(0, 1, 2'b01, 4, 0,   1, 0, 2'b01, 1, 4);
        add(0, 1, 2'b00, 4, 0,   0, 0, 2'b00, 0, 4);
        add(0, 1, 2'b00, 4, 0,   0, 0, 2'b00, 0, 4);
        add(0, 1, 2'b00, 4, 0,   1, 1, 2'b00, 0, 4);
        add(0, 1, 2'b00, 4, 0,   1, 0, 2'b00, 0, 4);
        add(0, 1, 2'b00, 4, 0,   0, 0, 2'b00, 0, 4);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; bus.req = tbl[i].req;
            bus.div_in0 = tbl[i].d0; bus.div_in1 = tbl[i].d1;
            cycle();
            chk("tbl_div_clk", int'(div_clk), int'(tbl[i].e_dc));
            chk("tbl_clk_en",  int'(clk_en),  int'(tbl[i].e_ce));
            chk("tbl_ack",     int'(bus.ack), int'(tbl[i].e_ack));
            chk("tbl_busy",    int'(busy),    int'(tbl[i].e_busy));
            chk("tbl_div_cur", int'(div_cur), int'(tbl[i].e_div));
        end

        // Simultaneous requests from a freshly reset priority pointer.
        rst = 1'b1; cycle(); rst = 1'b0;
        bus.req = 2'b11; bus.div_in0 = 8'd6; bus.div_in1 = 8'd3;
        wait_ack(2'b01, 12);
        chk("sim_first_div", int'(div_cur), 6);
        bus.req = 2'b10;
        wait_ack(2'b10, 16);
        chk("sim_second_div", int'(div_cur), 3);
        chk("sim_pat0", int'(div_clk), 1);
        cycle(); chk("sim_pat1", int'(div_clk), 1);
        cycle(); chk("sim_pat2", int'(div_clk), 0);
        bus.req = 2'b00; cycle(); cycle();
        bus.req = 2'b11; bus.div_in0 = 8'd6; bus.div_in1 = 8'd3;
        wait_ack(2'b01, 12);
        chk("rr_winner_div", int'(div_cur), 6);
        bus.req = 2'b00; cycle(); cycle();

        // Illegal divisor is rejected without touching the output.
        bus.req = 2'b10; bus.div_in1 = 8'd1;
        cycle();
        chk("ill_ack", int'(bus.ack), 2);
        chk("ill_err", int'(bus.err), 1);
        chk("ill_div", int'(div_cur), 6);
        bus.req = 2'b00; cycle(); cycle();

        // Change while parked, then restart.
        en = 1'b0; cycle(); cycle();
        bus.req = 2'b01; bus.div_in0 = 8'd7;
        cycle(); cycle();
        chk("park_ack", int'(bus.ack), 1);
        chk("park_div", int'(div_cur), 7);
        chk("park_dc",  int'(div_clk), 0);
        chk("park_ce",  int'(clk_en),  0);
        bus.req = 2'b00; cycle();
        en = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            cycle();
            pat[i] = div_clk;
        end
        chk("park_pattern", int'(pat), int'(7'b1111000));

        // Reset while a change is pending.
        bus.req = 2'b01; bus.div_in0 = 8'd9;
        cycle();
        chk("pend_busy", int'(busy), 1);
        rst = 1'b1; bus.req = 2'b00;
        cycle();
        rst = 1'b0;
        chk("rstp_ack",  int'(bus.ack), 0);
        chk("rstp_busy", int'(busy), 0);
        chk("rstp_div",  int'(div_cur), 5);
        cycle(); cycle();

        // Randomized requesters following the 4-phase protocol.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < 2; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        bus.req[i] = 1'b1;
                        if (i == 0) bus.div_in0 = 8'($urandom_range(0, 12));
                        else        bus.div_in1 = 8'($urandom_range(0, 12));
                    end
                end else if (bus.ack[i]) begin
                    if ($urandom_range(0, 2) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    if (i == 0) bus.div_in0 = 8'($urandom_range(0, 12));
                    else        bus.div_in1 = 8'($urandom_range(0, 12));
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_ratio_ctrl.md
# clk_div_ratio_ctrl

Runtime-programmable divide-ratio controller for the 50%-duty clock frequency divider family. It owns the active divisor and generates the divided clock (`div_clk`) and a one-cycle period-start enable (`clk_en`), both from flops in the `clk` domain. Two requesters share the divisor setting through a round-robin arbiter with a 4-phase req/ack handshake. An accepted change takes effect only at a period boundary, so the output never produces a runt pulse.

## Interface
- `W`, 8: divisor width; the legal divisor range is 2..2^W-1.
- `DEFAULT_DIV`, 5: divisor loaded at reset; must lie in 2..2^W-1.

- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `en`  in  1  run enable. When low, the counter parks.
- `req`  in  2  change requests, one bit per requester. Level, held until ack.
- `div_in0`  in  W  divisor requested by requester 0.
- `div_in1`  in  W  divisor requested by requester 1.
- `ack`  out  2  per-requester acknowledge. Level, held until that req drops.
- `err`  out  1  request rejected (divisor < 2). Valid while `ack` is high.
- `busy`  out  1  controller not in IDLE.
- `div_cur`  out  W  active divisor.
- `div_clk`  out  1  divided clock, registered.
- `clk_en`  out  1  high for the first `clk` cycle of each output period.

## Operation
- **Counter `cnt`** (W bits) runs 0..div_cur-1 and wraps to 0. When `en`=0 it holds at div_cur-1.
- **Output decode.** In any cycle where `cnt`=k:
  - `div_clk` = (k < (div_cur+1)/2). High for ceil(N/2) cycles and low for floor(N/2) cycles; exactly 50% for even N.
  - `clk_en` = (k==0).
  - Both are flops loaded from the decode of next-`cnt`, so they have no combinational path to the output.
- **Period boundary** is the clock edge where `cnt`==div_cur-1 and `en`=1, or any edge while `en`=0 (parked).
- **FSM states: IDLE, PEND, ACK.**
  - **IDLE:** if any `req` is high, grant one requester `g` and latch `pend` from `div_in<g>`.
    - If `pend` < 2: go to ACK, set `ack[g]`=1 and `err`=1. `div_cur` is unchanged.
    - Otherwise go to PEND.
  - **PEND:** wait for a period boundary. At the boundary:
    - `div_cur` <= `pend`.
    - `cnt` <= 0 if `en`=1, else `pend`-1.
    - `ack[g]` <= 1, `err` <= 0, then go to ACK.
    - Changes to `div_in<g>` after the grant are ignored.
  - **ACK:** hold `ack[g]` (and `err`) until `req[g]` samples low. Then clear `ack`/`err` and return to IDLE.
- **Arbitration (round-robin, 2-way).**
  - The last-granted requester gets the lowest priority.
  - After reset, requester 0 has priority.
  - A requester that is not granted keeps `req` high and waits; it is served after the ACK→IDLE return.
- **`busy`** = (state != IDLE).
- **Reset values.** state=IDLE, `div_cur`=DEFAULT_DIV, `cnt`=DEFAULT_DIV-1, `ack`=0, `err`=0, `div_clk`=0, `clk_en`=0, priority pointer → requester 0.
- **Reset mid-operation.** A pending change is discarded and no ack is issued. A requester still holding `req` is re-granted afresh after reset.
- **`en` falls mid-period.** `cnt` jumps to div_cur-1 on the next edge, so `div_clk` goes low and the period is truncated. This is the only permitted truncation.
- **`en` rises.** The first cycle with `cnt`=0 follows on the next edge.

## Timing
- **Reset release.**
  - Cycle 1 after deassert: `cnt`=DEFAULT_DIV-1, outputs 0.
  - Cycle 2: `cnt`=0, `div_clk`=1, `clk_en`=1 (with `en`=1).
- **Grant latency.** A `req` sampled high in IDLE at edge e gives `busy`=1 from e+1.
- **Illegal request.** `ack`+`err` are high from e+1.
- **Legal request.** Let edge b be the first boundary at or after e+1.
  - The new `div_cur`, `cnt`=0 and `ack` are all visible from b+1.
  - `clk_en` is high in the same cycle as `ack` (when `en`=1).
  - Worst case from request to ack: div_cur+1 cycles.
- **Handshake completion.** `req[g]` sampled low at edge r drops `ack` and `busy` at r+1. The next grant can occur at edge r+1, becoming visible at r+2.

## Test plan
1. **Reset default.** Reset with DEFAULT_DIV=5, `en`=1 → after one parked cycle, `div_clk` repeats 1,1,1,0,0 and `clk_en` pulses every 5 cycles; `div_cur`=5, `busy`=0.
2. **Legal change at boundary.** Raise `req[0]` with `div_in0`=4 while `cnt`=1 → `busy` high next cycle; `ack[0]` asserts together with the first `clk_en` of a new period (3 edges later); then `div_clk` repeats 1,1,0,0. Drop `req[0]` → `ack[0]` clears one cycle later.
3. **Simultaneous requests.** Raise `req`=11 with `div_in0`=6 and `div_in1`=3 → divisor 6 is applied and acked first; then divisor 3 is acked with pattern 1,1,0. Repeat with `req`=11 → requester 0 wins (priority rotated after the grant to requester 1).
4. **Illegal divisor.** `div_in1`=1 → `ack[1]`=1 and `err`=1 one cycle after the grant; `div_cur` and `div_clk` unchanged.
5. **Change while parked.** With `en`=0, request 7 → `ack` within 2 cycles, `div_clk`/`clk_en` stay 0. Raise `en` → `cnt`=0 on the next edge, then `div_clk` shows 4 high and 3 low.
6. **Reset during PEND.** Request 9, then assert `rst` during PEND → no `ack` pulse; `div_cur`=5, `busy`=0 after reset.
